// File: rtl/fifo_stream_pkg.sv
// Shared types and constants for the sync_fifo read-side stream adapter.
package fifo_stream_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned BUF_DEPTH      = 2;

  typedef logic [1:0]                buf_cnt_t;
  typedef logic [DATA_WIDTH_DEF-1:0] data_t;

endpackage

// File: rtl/fifo_stream_reader_skid_buf2.sv
// Two-entry register skid buffer: circular head/count, one write port, one pop.
module skid_buf2
  import fifo_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  pop,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [1:0]            cnt
);

  logic [DATA_WIDTH-1:0] mem_q [2];
  logic                  head_q;
  buf_cnt_t              cnt_q, cnt_d;
  logic                  wr_idx;

  // Write lands just past the current occupants; with a same-cycle pop this is
  // the slot right after the post-pop head, so data flows through with no bubble.
  always_comb begin
    wr_idx = head_q ^ cnt_q[0];
    cnt_d  = cnt_q + buf_cnt_t'(wr_en) - buf_cnt_t'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      head_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (pop) begin
        head_q <= ~head_q;
      end
      if (wr_en) begin
        mem_q[wr_idx] <= wr_data;
      end
    end
  end

  assign valid   = (cnt_q != '0);
  assign rd_data = mem_q[head_q];
  assign cnt     = cnt_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side adapter for sync_fifo: issues rd_en, captures rd_data, presents a
// valid/ready stream. Optional counters xfer_cnt/stall_cnt under FIFO_STREAM_STATS_EN.
module fifo_stream_reader
  import fifo_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_PTR   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  input  logic [FIFO_PTR:0]     fifo_data_avail,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready
`ifdef FIFO_STREAM_STATS_EN
  ,
  output logic [31:0]           xfer_cnt,
  output logic [31:0]           stall_cnt
`endif
);

  logic              inflight_q;
  logic              pop;
  logic [1:0]        buf_cnt;
  logic [2:0]        occ_next;
  logic [FIFO_PTR:0] inflight_ext;

  assign pop = m_valid && m_ready;

  // data_avail lags one cycle behind a read, so an outstanding read is
  // subtracted before deciding another word is really there.
  always_comb begin
    inflight_ext    = '0;
    inflight_ext[0] = inflight_q;
    occ_next        = {1'b0, buf_cnt} + {2'b00, inflight_q} - {2'b00, pop};
    fifo_rd_en      = !rst && (fifo_data_avail > inflight_ext) && (occ_next < 3'd2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= fifo_rd_en;
    end
  end

  skid_buf2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (inflight_q),
    .wr_data (fifo_rd_data),
    .pop     (pop),
    .valid   (m_valid),
    .rd_data (m_data),
    .cnt     (buf_cnt)
  );

`ifdef FIFO_STREAM_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (pop) begin
        xfer_cnt <= xfer_cnt + 32'd1;
      end
      if (m_valid && !m_ready) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
`endif

`ifndef SYNTHESIS
  a_no_read_when_empty: assert property (@(posedge clk) disable iff (rst)
    !(fifo_rd_en && fifo_empty));
  a_buf_cnt_max: assert property (@(posedge clk) disable iff (rst) buf_cnt != 2'd3);
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader with a behavioural sync_fifo and a queue-based stream model.
module tb_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_rd_en;
  logic [31:0] fifo_rd_data = '0;
  logic        fifo_empty = 1'b1;
  logic [4:0]  fifo_data_avail = '0;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_ready = 1'b0;
`ifdef FIFO_STREAM_STATS_EN
  logic [31:0] xfer_cnt;
  logic [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  fifo_stream_reader #(
    .DATA_WIDTH (32),
    .FIFO_PTR   (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .fifo_rd_en      (fifo_rd_en),
    .fifo_rd_data    (fifo_rd_data),
    .fifo_empty      (fifo_empty),
    .fifo_data_avail (fifo_data_avail),
    .m_valid         (m_valid),
    .m_data          (m_data),
    .m_ready         (m_ready)
`ifdef FIFO_STREAM_STATS_EN
    ,
    .xfer_cnt        (xfer_cnt),
    .stall_cnt       (stall_cnt)
`endif
  );

  // Behavioural sync_fifo, depth 16: rd_data one cycle after rd_en, data_avail
  // reports the stored count as of the previous edge.
  logic [31:0] fifo_q[$];
  logic [31:0] wr_q[$];
  int          cnt_now = 0;

  always @(posedge clk) begin
    if (rst) begin
      fifo_q.delete();
      wr_q.delete();
      cnt_now = 0;
      fifo_data_avail <= '0;
      fifo_empty      <= 1'b1;
    end else begin
      if (fifo_rd_en && fifo_q.size() > 0) fifo_rd_data <= fifo_q.pop_front();
      if (wr_q.size() > 0 && fifo_q.size() < 16) fifo_q.push_back(wr_q.pop_front());
      fifo_data_avail <= 5'(cnt_now);
      cnt_now = fifo_q.size();
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  logic [31:0] exp_q[$];
  logic [31:0] exp;
  int          passed = 0;
  int          total = 0;
  int          cyc = 0;
  int          xfer_m = 0;
  int          stall_m = 0;
  logic        o_valid, o_rd_en, o_empty, o_beat;
  logic [31:0] o_data;

  // One clock: sample at the falling edge, update the stream-level model, move past the edge.
  task automatic tick();
    @(negedge clk);
    o_valid = m_valid;
    o_data  = m_data;
    o_rd_en = fifo_rd_en;
    o_empty = fifo_empty;
    o_beat  = m_valid && m_ready && !rst;
    if (rst) begin
      xfer_m  = 0;
      stall_m = 0;
    end else begin
      if (o_beat) xfer_m++;
      if (m_valid && !m_ready) stall_m++;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if (o_rd_en !== 1'b0 || o_valid !== 1'b0 || o_data !== 32'h0)
        $display("FAIL idle_%0d: rd_en=%b valid=%b data=%h, required 0 0 00000000",
                 i, o_rd_en, o_valid, o_data);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int got = 0;
    int last = 0;
    int bad = 0;
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      fifo_q.push_back(~(32'(i) + 32'd1));
      exp_q.push_back(~(32'(i) + 32'd1));
    end
    for (int k = 0; k < 60 && got < 16; k++) begin
      tick();
      if (o_rd_en && o_empty) bad++;
      if (o_beat) begin
        total++;
        if (exp_q.size() == 0) $display("FAIL b2b_extra: beat %h, required none", o_data);
        else begin
          exp = exp_q.pop_front();
          if (o_data !== exp) $display("FAIL b2b_data: got %h, required %h", o_data, exp);
          else passed++;
        end
        if (got > 0) begin
          total++;
          if (cyc !== last + 1)
            $display("FAIL b2b_gap: beat at cycle %0d, required %0d", cyc, last + 1);
          else passed++;
        end
        last = cyc;
        got++;
      end
    end
    total++;
    if (got !== 16) $display("FAIL b2b_count: got %0d beats, required 16", got);
    else passed++;
    total++;
    if (bad !== 0) $display("FAIL b2b_rd_empty: %0d reads while empty, required 0", bad);
    else passed++;
  endtask

  task automatic test_stall();
    int pulses = 0;
    int got = 0;
    logic [31:0] w;
    m_ready = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      w = $urandom;
      fifo_q.push_back(w);
      exp_q.push_back(w);
    end
    for (int k = 0; k < 12; k++) begin
      tick();
      if (o_rd_en) pulses++;
      if (o_valid) begin
        total++;
        if (o_data !== exp_q[0]) $display("FAIL stall_hold: got %h, required %h", o_data, exp_q[0]);
        else passed++;
      end
    end
    total++;
    if (pulses !== 2) $display("FAIL stall_pulses: got %0d, required 2", pulses);
    else passed++;
    total++;
    if (o_valid !== 1'b1) $display("FAIL stall_valid: got %b, required 1", o_valid);
    else passed++;
    total++;
    if (fifo_data_avail !== 5'd6) $display("FAIL stall_avail: got %0d, required 6", fifo_data_avail);
    else passed++;
    m_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (o_beat) begin
        total++;
        if (exp_q.size() == 0) $display("FAIL stall_extra: beat %h, required none", o_data);
        else begin
          exp = exp_q.pop_front();
          if (o_data !== exp) $display("FAIL stall_data: got %h, required %h", o_data, exp);
          else passed++;
        end
        got++;
      end
    end
    total++;
    if (got !== 8) $display("FAIL stall_count: got %0d beats, required 8", got);
    else passed++;
  endtask

  task automatic test_toggle();
    int got = 0;
    logic [31:0] w;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 30; i++) begin
      w = $urandom;
      wr_q.push_back(w);
      exp_q.push_back(w);
    end
    for (int k = 0; k < 300 && got < 30; k++) begin
      m_ready = (k % 2 == 0);
      tick();
      if (o_beat) begin
        total++;
        if (exp_q.size() == 0) $display("FAIL toggle_extra: beat %h, required none", o_data);
        else begin
          exp = exp_q.pop_front();
          if (o_data !== exp) $display("FAIL toggle_data: got %h, required %h", o_data, exp);
          else passed++;
        end
        got++;
      end
    end
    total++;
    if (got !== 30) $display("FAIL toggle_count: got %0d beats, required 30", got);
    else passed++;
`ifdef FIFO_STREAM_STATS_EN
    total++;
    if (xfer_cnt !== 32'd30) $display("FAIL xfer_cnt: got %0d, required 30", xfer_cnt);
    else passed++;
    total++;
    if (stall_cnt !== 32'(stall_m))
      $display("FAIL stall_cnt: got %0d, required %0d", stall_cnt, stall_m);
    else passed++;
`endif
  endtask

  task automatic test_reset_mid();
    int rds = 0;
    int got = 0;
    logic [31:0] w;
    m_ready = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      w = $urandom;
      fifo_q.push_back(w);
      exp_q.push_back(w);
    end
    for (int k = 0; k < 40 && rds < 3; k++) begin
      tick();
      if (o_rd_en) rds++;
      if (o_beat) begin
        total++;
        exp = exp_q.pop_front();
        if (o_data !== exp) $display("FAIL rstmid_pre: got %h, required %h", o_data, exp);
        else passed++;
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    tick();
    total++;
    if (o_valid !== 1'b0 || o_data !== 32'h0 || o_rd_en !== 1'b0)
      $display("FAIL rstmid_clear: valid=%b data=%h rd_en=%b, required 0 00000000 0",
               o_valid, o_data, o_rd_en);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      w = 32'hA5A5_0000 + 32'(i);
      fifo_q.push_back(w);
      exp_q.push_back(w);
    end
    for (int k = 0; k < 30; k++) begin
      tick();
      if (o_beat) begin
        total++;
        if (exp_q.size() == 0) $display("FAIL rstmid_extra: beat %h, required none", o_data);
        else begin
          exp = exp_q.pop_front();
          if (o_data !== exp) $display("FAIL rstmid_data: got %h, required %h", o_data, exp);
          else passed++;
        end
        got++;
      end
    end
    total++;
    if (got !== 3) $display("FAIL rstmid_count: got %0d beats, required 3", got);
    else passed++;
  endtask

  task automatic test_latency();
    int rd_cyc = -1;
    int v_cyc = -1;
    logic [31:0] v_data = '0;
    int got = 0;
    m_ready = 1'b0;
    fifo_q.push_back(32'h1215_3524);
    for (int k = 0; k < 20 && v_cyc < 0; k++) begin
      tick();
      if (o_rd_en && rd_cyc < 0) rd_cyc = cyc;
      if (o_valid) begin
        v_cyc = cyc;
        v_data = o_data;
      end
    end
    total++;
    if (rd_cyc < 0 || v_cyc - rd_cyc !== 2)
      $display("FAIL latency: rd_en at %0d valid at %0d, required 2 cycles apart", rd_cyc, v_cyc);
    else passed++;
    total++;
    if (v_data !== 32'h1215_3524) $display("FAIL latency_data: got %h, required 12153524", v_data);
    else passed++;
    m_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (o_beat) got++;
    end
    total++;
    if (got !== 1) $display("FAIL latency_beats: got %0d, required 1", got);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_toggle();
    test_reset_mid();
    test_latency();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
